// File: rtl/ascii_case_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ascii_case_sequencer_pkg
//   Shared encodings for the ASCII case sequencer:
//     - conversion mode codes (pass / to-upper / to-lower / toggle)
//     - sequencer state codes (IDLE, RUN, FLUSH, DONE)
//     - ASCII letter range bounds and the upper/lower case offset
//     - small helpers that classify a character as an upper or lower letter
// ----------------------------------------------------------------------------
package ascii_case_sequencer_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_PASS   = 2'b00;
    localparam mode_t MODE_UPPER  = 2'b01;
    localparam mode_t MODE_LOWER  = 2'b10;
    localparam mode_t MODE_TOGGLE = 2'b11;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [7:0] UPPER_LO   = 8'h41;
    localparam logic [7:0] UPPER_HI   = 8'h5A;
    localparam logic [7:0] LOWER_LO   = 8'h61;
    localparam logic [7:0] LOWER_HI   = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    function automatic logic is_upper_f(input logic [7:0] c);
        return (c >= UPPER_LO) && (c <= UPPER_HI);
    endfunction

    function automatic logic is_lower_f(input logic [7:0] c);
        return (c >= LOWER_LO) && (c <= LOWER_HI);
    endfunction

endpackage

// File: rtl/ascii_case_sequencer_case_map.sv
// ----------------------------------------------------------------------------
// ascii_case_sequencer_case_map
//   Purely combinational character mapper (the case_map stage).
//   Ports:
//     char_in  [7:0] in   ASCII character to convert
//     mode     [1:0] in   conversion mode (pass/upper/lower/toggle)
//     mapped   [7:0] out  converted character
//     changed        out  mapped differs from char_in
//     is_upper       out  mapped is an uppercase letter 0x41-0x5A
//   Non-letter codes pass through unchanged in every mode.
// ----------------------------------------------------------------------------
module ascii_case_sequencer_case_map
    import ascii_case_sequencer_pkg::*;
(
    input  logic [7:0] char_in,
    input  logic [1:0] mode,
    output logic [7:0] mapped,
    output logic       changed,
    output logic       is_upper
);

    logic in_upper;
    logic in_lower;

    assign in_upper = is_upper_f(char_in);
    assign in_lower = is_lower_f(char_in);

    always_comb begin
        mapped = char_in;
        case (mode)
            MODE_UPPER:  if (in_lower) mapped = char_in - CASE_DELTA;
            MODE_LOWER:  if (in_upper) mapped = char_in + CASE_DELTA;
            MODE_TOGGLE: begin
                if (in_lower)      mapped = char_in - CASE_DELTA;
                else if (in_upper) mapped = char_in + CASE_DELTA;
            end
            default:     mapped = char_in;
        endcase
    end

    assign changed  = (mapped != char_in);
    assign is_upper = is_upper_f(mapped);

endmodule

// File: rtl/ascii_case_sequencer.sv
// ----------------------------------------------------------------------------
// ascii_case_sequencer
//   Streams one ASCII string per start request, converting letter case
//   through a single output register stage with valid/ready handshaking.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     start, mode[1:0]         begin a string (IDLE only), mode latched then
//     in_valid/in_data/in_last input character stream; in_ready = accept
//     out_valid/out_data/out_last/out_cap, out_ready   output stream
//     busy                     not IDLE
//     done                     one-cycle pulse when the string completes
//     trunc                    string ended by MAX_LEN rather than in_last
//     char_count, conv_count   accepted / changed characters (saturating)
// ----------------------------------------------------------------------------
module ascii_case_sequencer
    import ascii_case_sequencer_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             out_cap,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             trunc,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] conv_count
);

    localparam logic [CNT_W:0] MAX_LEN_C = (CNT_W+1)'(MAX_LEN);

    state_t           state_q,      state_d;
    mode_t            mode_q,       mode_d;
    logic             out_valid_q,  out_valid_d;
    logic [7:0]       out_data_q,   out_data_d;
    logic             out_last_q,   out_last_d;
    logic             out_cap_q,    out_cap_d;
    logic             trunc_q,      trunc_d;
    logic [CNT_W-1:0] char_count_q, char_count_d;
    logic [CNT_W-1:0] conv_count_q, conv_count_d;

    logic [7:0]       mapped;
    logic             changed;
    logic             mapped_upper;
    logic             xfer;
    logic             hit_max;
    logic             last_char;
    logic [CNT_W:0]   count_plus1;

    ascii_case_sequencer_case_map u_case_map (
        .char_in  (in_data),
        .mode     (mode_q),
        .mapped   (mapped),
        .changed  (changed),
        .is_upper (mapped_upper)
    );

    assign in_ready    = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign xfer        = in_valid && in_ready;
    // One extra bit so the comparison against MAX_LEN cannot wrap.
    assign count_plus1 = {1'b0, char_count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit_max     = (count_plus1 == MAX_LEN_C);
    assign last_char   = in_last || hit_max;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_cap_d    = out_cap_q;
        trunc_d      = trunc_q;
        char_count_d = char_count_q;
        conv_count_d = conv_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    mode_d       = mode;
                    char_count_d = '0;
                    conv_count_d = '0;
                    trunc_d      = 1'b0;
                end
            end
            ST_RUN:   if (xfer && last_char) state_d = ST_FLUSH;
            ST_FLUSH: if (out_valid_q && out_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // xfer only happens in RUN, so it never collides with the IDLE clears.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mapped;
            out_last_d  = last_char;
            out_cap_d   = mapped_upper;
            if (hit_max && !in_last) trunc_d = 1'b1;
            if (char_count_q != '1) char_count_d = char_count_q + 1'b1;
            if (changed && (conv_count_q != '1)) conv_count_d = conv_count_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_PASS;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_cap_q    <= 1'b0;
            trunc_q      <= 1'b0;
            char_count_q <= '0;
            conv_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_cap_q    <= out_cap_d;
            trunc_q      <= trunc_d;
            char_count_q <= char_count_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_cap    = out_cap_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign trunc      = trunc_q;
    assign char_count = char_count_q;
    assign conv_count = conv_count_q;

endmodule
